// File: rtl/qpsk_byte_packer.sv
// qpsk_byte_packer: tracks the subcarrier bin of each demapped QPSK dibit,
// drops pilot/null bins through DATA_MASK, packs the data dibits MSB-first
// into bytes and queues them in a small show-ahead FIFO toward the decoder.
module qpsk_byte_packer #(
    parameter int                N_SC       = 64,
    parameter logic [N_SC-1:0]   DATA_MASK  = 64'hFDFF_F7C0_07DF_FF7E,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sym_en_i,
    input  logic [1:0] sym_i,
    input  logic       sym_start_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    input  logic       byte_ready_i,
    output logic       sym_done_o,
    output logic       overflow_o
);

    localparam int BW = (N_SC > 1) ? $clog2(N_SC) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIN = BW'(N_SC - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // bin position, packing state and status registers
    logic [BW-1:0] bin_q, bin_d;
    logic [1:0]    pcnt_q, pcnt_d;
    logic [7:0]    acc_q, acc_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    // FIFO state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    // packer datapath signals
    logic [BW-1:0] eff_bin;
    logic [1:0]    pbase;
    logic [7:0]    abase;
    logic [7:0]    place;
    logic          is_data;
    logic          last;
    logic          push;
    logic [7:0]    push_data;

    // FIFO control
    logic          full;
    logic          pop;
    logic          wr;

    // Packer: a strobed sym_start restarts at bin 0 and throws away any
    // partial byte; the last bin of a symbol flushes a zero-padded partial.
    always_comb begin
        eff_bin   = sym_start_i ? '0 : bin_q;
        pbase     = sym_start_i ? 2'd0 : pcnt_q;
        abase     = sym_start_i ? 8'd0 : acc_q;
        is_data   = DATA_MASK[eff_bin];
        last      = (eff_bin == LAST_BIN);
        place     = {sym_i, 6'b0} >> {pbase, 1'b0};
        bin_d     = bin_q;
        pcnt_d    = pcnt_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_data = 8'd0;
        if (sym_en_i) begin
            bin_d  = last ? '0 : eff_bin + BW'(1);
            done_d = last;
            acc_d  = abase;
            pcnt_d = pbase;
            if (is_data) begin
                acc_d  = abase | place;
                pcnt_d = pbase + 2'd1;      // 3 -> 0 on the 4th dibit
            end
            if (is_data && pbase == 2'd3) begin
                push      = 1'b1;
                push_data = acc_d;
                acc_d     = 8'd0;
            end else if (last && pcnt_d != 2'd0) begin
                push      = 1'b1;
                push_data = acc_d;
                acc_d     = 8'd0;
                pcnt_d    = 2'd0;
            end
        end
    end

    // FIFO bookkeeping: a push into a full FIFO only lands if a pop frees
    // the slot on the same edge, otherwise it is dropped and flagged.
    always_comb begin
        full   = (cnt_q == FULL_CNT);
        pop    = (cnt_q != '0) && byte_ready_i;
        wr     = push && (!full || pop);
        ovf_d  = ovf_q | (push && full && !pop);
        wptr_d = wr  ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (wr && !pop)      cnt_d = cnt_q + (AW + 1)'(1);
        else if (pop && !wr) cnt_d = cnt_q - (AW + 1)'(1);
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            pcnt_q <= 2'd0;
            acc_q  <= 8'd0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            bin_q  <= bin_d;
            pcnt_q <= pcnt_d;
            acc_q  <= acc_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage; contents only matter while the count says they are live
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= push_data;
    end

    // show-ahead output: head byte is forced to zero while empty
    always_comb begin
        byte_valid_o = (cnt_q != '0);
        byte_data_o  = byte_valid_o ? mem_q[rptr_q] : 8'd0;
        sym_done_o   = done_q;
        overflow_o   = ovf_q;
    end

endmodule
